// File: rtl/grf_scoreboard_if.sv
// rtl/grf_scoreboard_if.sv - D-stage issue / W-stage retire bundle between pipeline and GRF scoreboard
interface grf_scoreboard_if;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic        use_rs;
  logic        use_rt;
  logic        issue_en;
  logic        issue_we;
  logic [4:0]  issue_wa;
  logic        retire_en;
  logic [4:0]  retire_wa;
  logic        stall_D;
  logic [6:0]  outstanding;
  logic        err;
  logic [31:0] stall_cycles;

  modport master (
    output rs_D, rt_D, use_rs, use_rt, issue_en, issue_we, issue_wa, retire_en, retire_wa,
    input  stall_D, outstanding, err, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, use_rs, use_rt, issue_en, issue_we, issue_wa, retire_en, retire_wa,
    output stall_D, outstanding, err, stall_cycles
  );
endinterface

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - per-register pending-write scoreboard gating D-stage issue
// Optional stall-cycle statistics counter enabled by defining GRF_SB_STATS_EN.
module grf_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             reset,
  grf_scoreboard_if.slave sb
);
  localparam logic [CNT_W-1:0] PMAX = '1;
  localparam logic [CNT_W-1:0] PONE = CNT_W'(1);

  // Entry 0 is never written after reset, so $0 always reads as idle.
  logic [CNT_W-1:0] pend [32];
  logic [CNT_W-1:0] pend_rs, pend_rt, pend_wa, pend_ra;
  logic             hz_rs, hz_rt, stall;
  logic             acc, ret, same, inc_ok, dec_ok;
  logic [6:0]       outstanding_q;
  logic             err_q;

  assign pend_rs = pend[sb.rs_D];
  assign pend_rt = pend[sb.rt_D];
  assign pend_wa = pend[sb.issue_wa];
  assign pend_ra = pend[sb.retire_wa];

  // A read of the register W is writing for the last time is forwarded by the GRF.
  always_comb begin
    hz_rs = sb.use_rs && (sb.rs_D != 5'd0) && (pend_rs != '0) &&
            !(sb.retire_en && (sb.retire_wa == sb.rs_D) && (pend_rs == PONE));
    hz_rt = sb.use_rt && (sb.rt_D != 5'd0) && (pend_rt != '0) &&
            !(sb.retire_en && (sb.retire_wa == sb.rt_D) && (pend_rt == PONE));
  end

  assign stall = hz_rs | hz_rt;

  assign acc    = sb.issue_en & ~stall & sb.issue_we & (sb.issue_wa != 5'd0);
  assign ret    = sb.retire_en & (sb.retire_wa != 5'd0);
  assign same   = acc & ret & (sb.issue_wa == sb.retire_wa);
  assign inc_ok = acc & ~same & (pend_wa != PMAX);
  assign dec_ok = ret & ~same & (pend_ra != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
      outstanding_q <= 7'd0;
      err_q         <= 1'b0;
    end else begin
      if (inc_ok) pend[sb.issue_wa]  <= pend_wa + PONE;
      if (dec_ok) pend[sb.retire_wa] <= pend_ra - PONE;
      if ((acc & ~same & ~inc_ok) | (ret & ~same & ~dec_ok)) err_q <= 1'b1;
      case ({inc_ok, dec_ok})
        2'b10:   outstanding_q <= outstanding_q + 7'd1;
        2'b01:   outstanding_q <= outstanding_q - 7'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign sb.stall_D     = stall;
  assign sb.outstanding = outstanding_q;
  assign sb.err         = err_q;

`ifdef GRF_SB_STATS_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end

  assign sb.stall_cycles = stall_cnt;
`else
  assign sb.stall_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - directed plus randomized check of grf_scoreboard against a counter-array model
module tb_grf_scoreboard;
  localparam int CW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  grf_scoreboard_if sb ();

  grf_scoreboard #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .sb(sb));

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          pend_m [32];
  logic        err_m;
  logic [31:0] sc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic hz(input logic u, input logic [4:0] r);
    if (!u || r == 5'd0 || pend_m[r] == 0) return 1'b0;
    if (sb.retire_en && sb.retire_wa == r && pend_m[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 32; i++) s += pend_m[i];
    return s;
  endfunction

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic ien, input logic iwe, input logic [4:0] iwa,
                        input logic ren, input logic [4:0] rwa);
    sb.rs_D = rs; sb.rt_D = rt; sb.use_rs = urs; sb.use_rt = urt;
    sb.issue_en = ien; sb.issue_we = iwe; sb.issue_wa = iwa;
    sb.retire_en = ren; sb.retire_wa = rwa;
  endtask

  // One clock: check the combinational stall, advance the model, then check registered state.
  task automatic cycle();
    logic e_stall, a, r;
    #1;
    e_stall = hz(sb.use_rs, sb.rs_D) | hz(sb.use_rt, sb.rt_D);
    chk("stall_D", {31'd0, sb.stall_D}, {31'd0, e_stall});
    a = sb.issue_en && !e_stall && sb.issue_we && sb.issue_wa != 5'd0;
    r = sb.retire_en && sb.retire_wa != 5'd0;
    if (!reset) begin
      if (e_stall) sc_m = sc_m + 32'd1;
      if (!(a && r && sb.issue_wa == sb.retire_wa)) begin
        if (a) begin
          if (pend_m[sb.issue_wa] < MAXV) pend_m[sb.issue_wa]++;
          else err_m = 1'b1;
        end
        if (r) begin
          if (pend_m[sb.retire_wa] > 0) pend_m[sb.retire_wa]--;
          else err_m = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 0;
      err_m = 1'b0;
      sc_m  = 32'd0;
    end
    chk("outstanding", {25'd0, sb.outstanding}, model_sum());
    chk("err", {31'd0, sb.err}, {31'd0, err_m});
`ifdef GRF_SB_STATS_EN
    chk("stall_cycles", sb.stall_cycles, sc_m);
`else
    chk("stall_cycles", sb.stall_cycles, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
    err_m = 1'b0;
    sc_m  = 32'd0;

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    cycle();
    chk("reset_outstanding", {25'd0, sb.outstanding}, 32'd0);
    chk("reset_stall", {31'd0, sb.stall_D}, 32'd0);

    set_in(0, 0, 0, 0, 1, 1, 8, 0, 0);
    cycle();
    chk("issue8_outstanding", {25'd0, sb.outstanding}, 32'd1);
    set_in(8, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("stall_on_r8", {31'd0, sb.stall_D}, 32'd1);
    cycle(); cycle(); cycle();
    set_in(8, 0, 1, 0, 0, 0, 0, 1, 8);
    #1 chk("writethrough_r8", {31'd0, sb.stall_D}, 32'd0);
    cycle();
    chk("retire8_outstanding", {25'd0, sb.outstanding}, 32'd0);
`ifdef GRF_SB_STATS_EN
    chk("stall_cycles_3", sb.stall_cycles, 32'd3);
`else
    chk("stall_cycles_off", sb.stall_cycles, 32'd0);
`endif

    set_in(0, 0, 0, 0, 1, 1, 5, 0, 0);
    cycle(); cycle();
    set_in(0, 5, 0, 1, 0, 0, 0, 1, 5);
    #1 chk("pend2_still_stalls", {31'd0, sb.stall_D}, 32'd1);
    cycle();
    #1 chk("pend1_writethrough", {31'd0, sb.stall_D}, 32'd0);
    cycle();

    set_in(0, 0, 0, 0, 1, 1, 9, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 1, 1, 9, 1, 9);
    cycle();
    chk("same_reg_net0", {25'd0, sb.outstanding}, 32'd1);
    chk("same_reg_no_err", {31'd0, sb.err}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cycle();

    set_in(0, 0, 1, 0, 1, 1, 0, 0, 0);
    #1 chk("r0_no_stall", {31'd0, sb.stall_D}, 32'd0);
    cycle();
    chk("r0_untracked", {25'd0, sb.outstanding}, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 3);
    cycle();
    chk("underflow_err", {31'd0, sb.err}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();
    chk("err_sticky", {31'd0, sb.err}, 32'd1);

    reset = 1'b1; cycle(); reset = 1'b0;
    set_in(0, 0, 0, 0, 1, 1, 7, 0, 0);
    cycle(); cycle(); cycle(); cycle();
    chk("overflow_err", {31'd0, sb.err}, 32'd1);
    chk("overflow_sat", {25'd0, sb.outstanding}, 32'd3);
    set_in(7, 0, 1, 0, 1, 1, 7, 0, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_in(7, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("post_reset_stall", {31'd0, sb.stall_D}, 32'd0);
    chk("post_reset_outstanding", {25'd0, sb.outstanding}, 32'd0);
    chk("post_reset_err", {31'd0, sb.err}, 32'd0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      set_in(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Register-file scoreboard that schedules D-stage issue against the 32×32 general register file in the pipelined MIPS core. It keeps a per-register count of in-flight writes, issued when an instruction leaves D and retired when W writes the GRF. It raises `stall_D` while a source operand still has a write outstanding. The same-cycle GRF write-through case is exempt, because the register file forwards `WD` to the read ports in that cycle.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. Maximum outstanding writes per register is 2^CNT_W−1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `rs_D`  in  5  first source register of the instruction in D.
- `rt_D`  in  5  second source register of the instruction in D.
- `use_rs`  in  1  the D instruction reads `rs_D`.
- `use_rt`  in  1  the D instruction reads `rt_D`.
- `issue_en`  in  1  the D instruction requests to advance to E.
- `issue_we`  in  1  the issuing instruction will write the GRF.
- `issue_wa`  in  5  destination register of the issuing instruction.
- `retire_en`  in  1  W-stage GRF write this cycle (GRF `WE`).
- `retire_wa`  in  5  W-stage destination (GRF `WA`).
- `stall_D`  out  1  hold D and bubble E (combinational).
- `outstanding`  out  7  total in-flight writes across all registers.
- `err`  out  1  sticky: a counter overflow or underflow occurred.
- `stall_cycles`  out  32  count of cycles with `stall_D`=1 (see Configuration).

## Operation
- State:
  - `pend[1..31]`, each CNT_W bits.
  - `pend[0]` does not exist and always reads 0.
  - `outstanding`, `err`, `stall_cycles`.
- Source hazard, per operand X in {rs, rt}:
  - `hz_X` = `use_X` & (X≠0) & (`pend[X]`≠0) & ~(`retire_en` & `retire_wa`==X & `pend[X]`==1).
  - `stall_D` = `hz_rs` | `hz_rt`.
- Issue acceptance:
  - `acc` = `issue_en` & ~`stall_D` & `issue_we` & (`issue_wa`≠0).
  - `issue_en` while `stall_D`=1 is ignored; no state change.
- Retire acceptance: `ret` = `retire_en` & (`retire_wa`≠0).
- Counter update per register r at the clock edge:
  - `acc` only on r: `pend[r]`+1. If already 2^CNT_W−1: hold at max, set `err`.
  - `ret` only on r: `pend[r]`−1. If already 0: hold at 0, set `err`.
  - `acc` and `ret` both on r: `pend[r]` unchanged. This holds even at 0 or max; no `err`.
  - `acc` and `ret` on different registers: both updates apply independently.
- `outstanding` tracks the sum of `pend[]`:
  - +1 on a non-saturating accept.
  - −1 on a non-underflowing retire.
  - Net 0 when both occur.
  - Range 0..31×(2^CNT_W−1); 7 bits suffices for CNT_W≤2.
- Writes to `$0` are never tracked, never stall, and never set `err`.
- `err` clears only on reset.

## Timing
- Reset, synchronous on `clk`: all `pend` = 0, `outstanding` = 0, `err` = 0, `stall_cycles` = 0. Hence `stall_D` = 0 in the cycle after reset.
- Reset asserted mid-operation discards all in-flight tracking. The pipeline is flushed by the same reset.
- `stall_D` is purely combinational from current `pend`, `rs_D`/`rt_D`/`use_*`, and this cycle's retire. It has zero latency.
- Counter, `outstanding` and `err` updates are visible in the cycle after the triggering edge.
- Issue and retire in the same cycle on the same register is legal and nets zero.
- Write-through exemption: a D read of r is allowed in the same cycle W writes r, provided that write is the last outstanding one (`pend[r]`==1). The GRF returns `WD` on that read.
- With `pend[r]`==2 and r retiring, D still stalls; the younger write is pending.

## Configuration
- `GRF_SB_STATS_EN` defined:
  - `stall_cycles` increments each cycle with `stall_D`=1 and `reset`=0.
  - It wraps at 2^32.
- `GRF_SB_STATS_EN` undefined: no counter is built and `stall_cycles` is tied to 32'h0.

## Test plan
- Reset, then `issue_we`=1 to `issue_wa`=8 with `issue_en`=1 → next cycle `pend[8]`=1, `outstanding`=1. Then `rs_D`=8 with `use_rs`=1 → `stall_D`=1.
- Hold `rs_D`=8 stalled for 3 cycles, then `retire_en`=1, `retire_wa`=8 → `stall_D` falls to 0 in the retire cycle. Next cycle `outstanding`=0. `stall_cycles`=3 with the macro defined, 0 without.
- Two issues to reg 5 (`pend[5]`=2), then a retire of 5 with `rt_D`=5, `use_rt`=1 → `stall_D` stays 1. After the second retire → 0.
- Issue to reg 9 and retire of reg 9 in the same cycle with `pend[9]`=1 → `pend[9]` stays 1, `outstanding` unchanged, `err`=0.
- `issue_wa`=0 and `rs_D`=0 with `use_rs`=1 → no stall, `outstanding` stays 0. Retire of reg 3 with `pend[3]`=0 → `err`=1, and `err` remains 1 until reset.
- With CNT_W=2, 4 issues to reg 7 → `pend[7]`=3, `err`=1. Assert reset mid-sequence → next cycle all outputs 0.
